uart_tx: RTL and testbench

Parallel-to-serial UART transmitter; the sending end of the link that `UART_RX_TOP` receives. Takes one byte per handshake, frames it as start, 8 data bits LSB first, optional even/odd parity, and stop, and drives the serial line. Every bit is held for `prescale` clocks, so both ends share one clock and one `prescale` setting. Loopback into `UART_RX_TOP` is the system-level check.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_bit_timer.sv | 29 ++
 rtl/uart_tx.sv | 122 ++++++++++++
 tb/tb_uart_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM state encoding and the parity helper.
package uart_pkg;

    localparam int DATA_W     = 8;
    localparam int PRESCALE_W = 6;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Even parity makes the total count of ones even; odd parity makes it odd.
    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic typ);
        return typ ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts 0..period-1 and flags the last clock of each bit.
module uart_tx_bit_timer
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [PRESCALE_W-1:0] period,
    output logic [PRESCALE_W-1:0] cnt,
    output logic                  bit_done
);

    // period is never zero here; the caller maps a prescale of 0 to 1.
    assign bit_done = (cnt == period - PRESCALE_W'(1));

    // Count clocks within the current bit; load or end-of-bit restarts from 0.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst) begin
            cnt <= '0;
        end else if (load || bit_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, stop bit.
module uart_tx
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     P_DATA,
    input  logic                  data_valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    uart_state_t           state_q, state_d;
    logic [DATA_W-1:0]     data_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] period;
    logic [2:0]            idx_q, idx_d;
    logic                  tx_q, tx_d;
    logic [PRESCALE_W-1:0] cnt;
    logic                  bit_done;
    logic                  last_stop_clk;
    logic                  accept;
    logic                  timer_load;

    // A latched prescale of 0 behaves as 1 clock per bit.
    assign period = (prescale_q == '0) ? PRESCALE_W'(1) : prescale_q;

    // busy comes from registered state and the timer only, so an upstream
    // valid never loops combinationally back into busy.
    assign last_stop_clk = (state_q == STOP) && (cnt == period - PRESCALE_W'(1));
    assign busy          = (state_q != IDLE) && !last_stop_clk;
    assign accept        = data_valid && !busy;

    // Hold the timer at 0 while idle and restart it on every new frame.
    assign timer_load = (state_q == IDLE) || accept;

    assign TX_OUT = tx_q;

    uart_tx_bit_timer u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .period   (period),
        .cnt      (cnt),
        .bit_done (bit_done)
    );

    // Next state, next bit index and the value the line takes after this edge.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        idx_d   = idx_q;
        tx_d    = STOP_BIT;

        unique case (state_q)
            IDLE: begin
                if (accept) state_d = START;
            end
            START: begin
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
            STOP: begin
                if (bit_done) state_d = accept ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) idx_d = '0;

        // Line value is registered, so decode it from the upcoming state.
        unique case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = data_q[idx_d];
            PARITY:  tx_d = par_bit_q;
            default: tx_d = STOP_BIT;
        endcase
    end

    // FSM state, bit index and the registered serial line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tx_q    <= STOP_BIT;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

    // Frame registers capture the request on acceptance and hold for the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            prescale_q <= '0;
        end else if (accept) begin
            data_q     <= P_DATA;
            par_en_q   <= PAR_EN;
            par_bit_q  <= parity_bit(P_DATA, PAR_TYP);
            prescale_q <= prescale;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard of accepted frames, per-bit line checks.
module tb_uart_tx;

    localparam int LIMIT = 5000;

    logic       clk;
    logic       rst;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] prescale;
    logic       TX_OUT;
    logic       busy;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       pt;
        int         p;
    } frame_t;

    frame_t sb[$];
    int     checks = 0;
    int     errors = 0;

    uart_tx dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Present a request and hold it until the DUT accepts; returns 1 time unit after the accepting edge.
    task automatic drive(input logic [7:0] d, input logic pe, input logic pt,
                         input logic [5:0] p, input bit push);
        int waited;
        waited     = 0;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        prescale   = p;
        data_valid = 1'b1;
        while (busy !== 1'b0 && waited < LIMIT) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("accept_ready", busy, 0);
        if (busy !== 1'b0) begin
            data_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) sb.push_back('{d, pe, pt, int'(p)});
        #1;
        check("post_accept_line_busy", {TX_OUT, busy}, 2'b01);
    endtask

    // Watch the line, pop the expected frame at each start bit and check every bit period.
    task automatic monitor(input int n_frames, input bit chained);
        for (int f = 0; f < n_frames; f++) begin
            frame_t     fr;
            int         n;
            int         p;
            int         waited;
            int         busy_hi;
            logic       bits[11];
            logic       obs;
            logic [7:0] rx;

            if (f == 0 || !chained) begin
                waited = 0;
                do begin
                    @(negedge clk);
                    waited++;
                end while (TX_OUT !== 1'b0 && waited < LIMIT);
                check($sformatf("start_seen_f%0d", f), TX_OUT, 0);
                if (TX_OUT !== 1'b0) return;
            end else begin
                @(negedge clk);
                check($sformatf("b2b_no_gap_f%0d", f), TX_OUT, 0);
            end

            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() == 0) return;
            fr = sb.pop_front();

            p = (fr.p == 0) ? 1 : fr.p;
            n = fr.pe ? 11 : 10;
            bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) bits[i + 1] = fr.d[i];
            bits[9]  = fr.pe ? ((^fr.d) ^ fr.pt) : 1'b1;
            bits[10] = 1'b1;

            busy_hi = 0;
            rx      = '0;
            for (int b = 0; b < n; b++) begin
                obs = bits[b];
                for (int c = 0; c < p; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (TX_OUT !== bits[b]) obs = TX_OUT;
                    if (busy === 1'b1) busy_hi++;
                    if (b >= 1 && b <= 8 && c == p / 2) rx[b - 1] = TX_OUT;
                end
                check($sformatf("f%0d_bit%0d", f, b), obs, bits[b]);
            end
            check($sformatf("f%0d_rx_byte", f), rx, fr.d);
            check($sformatf("f%0d_busy_cycles", f), busy_hi, n * p - 1);
        end
        @(negedge clk);
        check("idle_after_frame", {TX_OUT, busy}, 2'b10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ghost;

        rst        = 1'b0;
        P_DATA     = '0;
        data_valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        prescale   = 6'd8;
        repeat (3) @(posedge clk);
        #1;
        check("reset_line_busy", {TX_OUT, busy}, 2'b10);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {TX_OUT, busy}, 2'b10);

        // Even parity, P=8: 0xA5 -> 0,1,0,1,0,0,1,0,1,0,1
        fork
            begin drive(8'hA5, 1'b1, 1'b0, 6'd8, 1'b1); data_valid = 1'b0; end
            monitor(1, 1'b0);
        join

        // Odd parity, P=16: 0x01 (parity 0) then 0x00 (parity 1)
        fork
            begin drive(8'h01, 1'b1, 1'b1, 6'd16, 1'b1); data_valid = 1'b0; end
            monitor(1, 1'b0);
        join
        fork
            begin drive(8'h00, 1'b1, 1'b1, 6'd16, 1'b1); data_valid = 1'b0; end
            monitor(1, 1'b0);
        join

        // No parity, P=8: 10-bit frame
        fork
            begin drive(8'hF0, 1'b0, 1'b0, 6'd8, 1'b1); data_valid = 1'b0; end
            monitor(1, 1'b0);
        join

        // Back-to-back with data_valid held, P=16
        fork
            begin
                drive(8'h3C, 1'b1, 1'b0, 6'd16, 1'b1);
                drive(8'h55, 1'b1, 1'b0, 6'd16, 1'b1);
                data_valid = 1'b0;
            end
            monitor(2, 1'b1);
        join

        // prescale of 0 behaves as one clock per bit
        fork
            begin drive(8'h5A, 1'b1, 1'b1, 6'd0, 1'b1); data_valid = 1'b0; end
            monitor(1, 1'b0);
        join

        // Mid-frame request and prescale change are ignored
        fork
            begin
                drive(8'hC3, 1'b0, 1'b0, 6'd8, 1'b1);
                data_valid = 1'b0;
                repeat (30) @(posedge clk);
                #1;
                P_DATA     = 8'hFF;
                prescale   = 6'd32;
                data_valid = 1'b1;
                @(posedge clk);
                #1;
                data_valid = 1'b0;
            end
            monitor(1, 1'b0);
        join
        ghost = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (TX_OUT !== 1'b1 || busy !== 1'b0) ghost = 1'b1;
        end
        check("no_ghost_frame", ghost, 0);

        // Reset during data bit 3 of 0x96 (bit 3 is 0)
        drive(8'h96, 1'b0, 1'b0, 6'd8, 1'b0);
        data_valid = 1'b0;
        repeat (34) @(posedge clk);
        #2;
        check("pre_reset_bit3", TX_OUT, 0);
        rst = 1'b0;
        #1;
        check("async_reset_line_busy", {TX_OUT, busy}, 2'b10);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_after_midframe_reset", {TX_OUT, busy}, 2'b10);

        // Clean frame after the abandoned one
        fork
            begin drive(8'h3A, 1'b1, 1'b1, 6'd8, 1'b1); data_valid = 1'b0; end
            monitor(1, 1'b0);
        join

        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
